// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: operand selects, ALU op codes,
// and the control half of a buffered issue entry.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ASEL_RS1      = 2'b00,
    ASEL_PC       = 2'b01,
    ASEL_ZERO     = 2'b10,
    ASEL_ZERO_ALT = 2'b11
  } asel_e;

  typedef enum logic [1:0] {
    BSEL_RS2  = 2'b00,
    BSEL_IMM  = 2'b01,
    BSEL_FOUR = 2'b10,
    BSEL_ZERO = 2'b11
  } bsel_e;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

  // Source indices are stored as 0 when that operand did not come from the
  // register file, so an index-0 match doubles as "not bypassable".
  typedef struct packed {
    logic [3:0] ctr;
    logic [4:0] rd;
    logic       wen;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
  } issue_ctl_t;

  function automatic logic fwd_hit(input logic       wen,
                                   input logic [4:0] rd,
                                   input logic [4:0] idx);
    return wen && (rd != 5'd0) && (rd == idx);
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer; output always comes from main.
// in_ready depends only on registered state. upd_* lets the owner rewrite held entries.
module skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [W-1:0] skid_data,
  input  logic         upd_en,
  input  logic [W-1:0] main_upd,
  input  logic [W-1:0] skid_upd
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         drain;
  logic [W-1:0] main_cur;
  logic [W-1:0] skid_cur;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign main_cur  = upd_en ? main_upd : main_q;
  assign skid_cur  = upd_en ? skid_upd : skid_q;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign skid_data = skid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_q     <= in_data;
      end
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_cur;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else begin
      // main is held: only a bypass rewrite can change it
      main_q <= main_cur;
      if (accept) begin
        skid_valid <= 1'b1;
        skid_q     <= in_data;
      end else if (skid_valid) begin
        skid_q <= skid_cur;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves operand selects at capture and buffers entries in a skid buffer.
// Define ALU_ISSUE_FWD_EN to compile in the writeback bypass (capture and held entries).
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [1:0]      in_asel,
  input  logic [1:0]      in_bsel,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic [3:0]      in_alu_ctr,
  input  logic            fwd_wen,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_ctr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wen
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    issue_ctl_t      ctl;
  } entry_t;

  localparam int unsigned W = $bits(entry_t);

  entry_t cap;
  entry_t main_e;
  entry_t skid_e;
  entry_t main_upd;
  entry_t skid_upd;
  logic   upd_en;

  always_comb begin
    cap             = '0;
    cap.pc          = in_pc;
    cap.ctl.ctr     = in_alu_ctr;
    cap.ctl.rd      = in_rd;
    cap.ctl.wen     = in_wen;
    case (asel_e'(in_asel))
      ASEL_RS1: cap.a = in_rs1;
      ASEL_PC:  cap.a = in_pc;
      default:  cap.a = '0;
    endcase
    case (bsel_e'(in_bsel))
      BSEL_RS2:  cap.b = in_rs2;
      BSEL_IMM:  cap.b = in_imm;
      BSEL_FOUR: cap.b = XLEN'(4);
      default:   cap.b = '0;
    endcase
`ifdef ALU_ISSUE_FWD_EN
    if (asel_e'(in_asel) == ASEL_RS1) begin
      cap.ctl.rs1_idx = in_rs1_idx;
      if (fwd_hit(fwd_wen, fwd_rd, in_rs1_idx)) cap.a = fwd_data;
    end
    if (bsel_e'(in_bsel) == BSEL_RS2) begin
      cap.ctl.rs2_idx = in_rs2_idx;
      if (fwd_hit(fwd_wen, fwd_rd, in_rs2_idx)) cap.b = fwd_data;
    end
`endif
  end

`ifdef ALU_ISSUE_FWD_EN
  // Held entries keep listening to writeback until they leave the stage.
  always_comb begin
    main_upd = main_e;
    skid_upd = skid_e;
    if (fwd_hit(fwd_wen, fwd_rd, main_e.ctl.rs1_idx)) main_upd.a = fwd_data;
    if (fwd_hit(fwd_wen, fwd_rd, main_e.ctl.rs2_idx)) main_upd.b = fwd_data;
    if (fwd_hit(fwd_wen, fwd_rd, skid_e.ctl.rs1_idx)) skid_upd.a = fwd_data;
    if (fwd_hit(fwd_wen, fwd_rd, skid_e.ctl.rs2_idx)) skid_upd.b = fwd_data;
  end
  assign upd_en = 1'b1;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wen, fwd_rd, fwd_data, in_rs1_idx, in_rs2_idx};
  assign main_upd   = main_e;
  assign skid_upd   = skid_e;
  assign upd_en     = 1'b0;
`endif

  skid_buf #(
    .W(W)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (cap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main_e),
    .skid_data (skid_e),
    .upd_en    (upd_en),
    .main_upd  (main_upd),
    .skid_upd  (skid_upd)
  );

  assign out_a       = main_e.a;
  assign out_b       = main_e.b;
  assign out_pc      = main_e.pc;
  assign out_alu_ctr = main_e.ctl.ctr;
  assign out_rd      = main_e.ctl.rd;
  assign out_wen     = main_e.ctl.wen;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries queued at accept,
// compared when the ALU side takes them.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [1:0]      in_asel = '0, in_bsel = '0;
  logic [4:0]      in_rs1_idx = '0, in_rs2_idx = '0, in_rd = '0;
  logic            in_wen = 1'b0;
  logic [3:0]      in_alu_ctr = '0;
  logic            fwd_wen = 1'b0;
  logic [4:0]      fwd_rd = '0;
  logic [XLEN-1:0] fwd_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_a, out_b, out_pc;
  logic [3:0]      out_alu_ctr;
  logic [4:0]      out_rd;
  logic            out_wen;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_asel(in_asel), .in_bsel(in_bsel),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd),
    .in_wen(in_wen), .in_alu_ctr(in_alu_ctr),
    .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctr(out_alu_ctr),
    .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen)
  );

  always #5 clk = ~clk;

  function automatic exp_t model();
    exp_t e;
    e.pc  = in_pc;
    e.ctr = in_alu_ctr;
    e.rd  = in_rd;
    e.wen = in_wen;
    case (in_asel)
      2'b00: begin
        e.a = in_rs1;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_wen && fwd_rd != 0 && fwd_rd == in_rs1_idx) e.a = fwd_data;
`endif
      end
      2'b01:   e.a = in_pc;
      default: e.a = 32'd0;
    endcase
    case (in_bsel)
      2'b00: begin
        e.b = in_rs2;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_wen && fwd_rd != 0 && fwd_rd == in_rs2_idx) e.b = fwd_data;
`endif
      end
      2'b01:   e.b = in_imm;
      2'b10:   e.b = 32'd4;
      default: e.b = 32'd0;
    endcase
    return e;
  endfunction

  // Sampled mid-cycle: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        exp_t got;
        exp_t exp;
        n_out++;
        n_cmp++;
        got = {out_pc, out_a, out_b, out_alu_ctr, out_rd, out_wen};
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output pc=%h a=%h b=%h", out_pc, out_a, out_b);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL scoreboard got pc=%h a=%h b=%h ctr=%h rd=%0d wen=%b required pc=%h a=%h b=%h ctr=%h rd=%0d wen=%b",
                     got.pc, got.a, got.b, got.ctr, got.rd, got.wen,
                     exp.pc, exp.a, exp.b, exp.ctr, exp.rd, exp.wen);
          end
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back(model());
    end
  end

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm,
                       input logic [1:0] asel, bsel,
                       input logic [4:0] r1, r2,
                       input logic [3:0] ctr);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_asel = asel; in_bsel = bsel;
    in_rs1_idx = r1; in_rs2_idx = r2;
    in_rd = pc[4:0]; in_wen = pc[0]; in_alu_ctr = ctr;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) return;
    end
    n_cmp++; n_err++;
    $display("FAIL drain_timeout pending=%0d required 0", sb.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_handshake out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
    n_cmp++;
    if ({out_a, out_b, out_pc, out_alu_ctr, out_rd, out_wen} !== '0) begin
      n_err++; $display("FAIL reset_payload a=%h b=%h pc=%h required 0", out_a, out_b, out_pc);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(32'h100, 32'h0, 32'h0, 32'h0, 2'b01, 2'b10, 5'd0, 5'd0, 4'h0);
    wait_accept();
    n_cmp++;
    if (out_valid !== 1'b1 || out_a !== 32'h100 || out_b !== 32'd4) begin
      n_err++; $display("FAIL basic_latency out_valid=%b a=%h b=%h required 1 100 4", out_valid, out_a, out_b);
    end
    wait_drain();
  endtask

  task automatic test_operands();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] sel;
      sel = i[3:0];
      drive($urandom, $urandom, $urandom, $urandom, sel[1:0], sel[3:2],
            5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 4'($urandom));
      wait_accept();
    end
    wait_drain();
  endtask

  task automatic test_back_to_back_hold();
    out_ready = 1'b0;
    drive(32'h1, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h1);
    wait_accept();
    drive(32'h2, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h2);
    wait_accept();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b01 || out_pc !== 32'h1) begin
      n_err++; $display("FAIL hold_two in_ready/out_valid=%b pc=%h required 01 1", {in_ready, out_valid}, out_pc);
    end
    drive(32'h3, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h3);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_pc !== 32'h1 || out_a !== 32'h1) begin
      n_err++; $display("FAIL hold_stable in_ready=%b pc=%h a=%h required 0 1 1", in_ready, out_pc, out_a);
    end
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
  endtask

  task automatic test_stream();
    int lows;
    int start;
    lows = 0;
    start = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(32'h200 + 32'(i), $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom),
            5'd1, 5'd2, 4'($urandom));
      @(negedge clk);
      if (!in_ready) lows++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    n_cmp++;
    if (lows !== 0) begin
      n_err++; $display("FAIL stream_in_ready low_cycles=%0d required 0", lows);
    end
    n_cmp++;
    if (n_out - start !== 16) begin
      n_err++; $display("FAIL stream_count transfers=%0d required 16", n_out - start);
    end
  endtask

  task automatic test_fwd();
    logic [31:0] exp_a;
    exp_t        t;
    out_ready = 1'b1;
    fwd_wen = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h22;
    drive(32'h300, 32'h11, 32'h0, 32'h8, 2'b00, 2'b01, 5'd5, 5'd0, 4'h0);
    wait_accept();
    fwd_wen = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    exp_a = 32'h22;
`else
    exp_a = 32'h11;
`endif
    n_cmp++;
    if (out_a !== exp_a) begin
      n_err++; $display("FAIL fwd_capture a=%h required %h", out_a, exp_a);
    end
    fwd_wen = 1'b1; fwd_rd = 5'd0; fwd_data = 32'h22;
    drive(32'h304, 32'h11, 32'h0, 32'h8, 2'b00, 2'b01, 5'd0, 5'd0, 4'h0);
    wait_accept();
    fwd_wen = 1'b0;
    n_cmp++;
    if (out_a !== 32'h11) begin
      n_err++; $display("FAIL fwd_rd_zero a=%h required 11", out_a);
    end
    fwd_wen = 1'b1; fwd_rd = 5'd7; fwd_data = 32'h77;
    drive(32'h308, 32'h1, 32'h55, 32'h0, 2'b01, 2'b00, 5'd7, 5'd7, 4'h2);
    wait_accept();
    fwd_wen = 1'b0;
    wait_drain();
    // held entry sees a later writeback
    out_ready = 1'b0;
    drive(32'h30c, 32'h33, 32'h0, 32'h0, 2'b00, 2'b11, 5'd9, 5'd0, 4'h3);
    wait_accept();
    fwd_wen = 1'b1; fwd_rd = 5'd9; fwd_data = 32'h44;
    @(posedge clk); #1;
    fwd_wen = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    exp_a = 32'h44;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      t.a = 32'h44;
      sb.push_front(t);
    end
`else
    exp_a = 32'h33;
`endif
    n_cmp++;
    if (out_a !== exp_a) begin
      n_err++; $display("FAIL fwd_held a=%h required %h", out_a, exp_a);
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_flush();
    int start;
    out_ready = 1'b0;
    drive(32'h401, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h1);
    wait_accept();
    drive(32'h402, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h2);
    wait_accept();
    drive(32'h403, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_full out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
    start = n_out;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(32'h404, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h4);
    wait_accept();
    drive(32'h405, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h5);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_accept out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_out !== start) begin
      n_err++; $display("FAIL flush_emitted count=%0d required 0", n_out - start);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(32'h501, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h1);
    wait_accept();
    drive(32'h502, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, 5'd0, 5'd0, 4'h2);
    wait_accept();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_mid_handshake out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
    n_cmp++;
    if ({out_a, out_b, out_pc, out_alu_ctr, out_rd, out_wen} !== '0) begin
      n_err++; $display("FAIL reset_mid_payload a=%h b=%h pc=%h required 0", out_a, out_b, out_pc);
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(32'h600, 32'h0, 32'h0, 32'h0, 2'b01, 2'b10, 5'd0, 5'd0, 4'h6);
    wait_accept();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h600) begin
      n_err++; $display("FAIL reset_mid_first out_valid=%b pc=%h required 1 600", out_valid, out_pc);
    end
    wait_drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_operands();
    test_back_to_back_hold();
    test_stream();
    test_fwd();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
